// File: rtl/q_move_resolver.sv
// q_move_resolver
//   Grid-maze move resolver for the Q-learning agent. Given a current state
//   and an action it produces the resolved next state and an outcome class
//   (MOVED / EDGE / BLOCKED / GOAL). The blocked-cell list is scanned one
//   entry per cycle behind a start/done handshake.
//
// Ports
//   done_clk        clock
//   rst             synchronous, active-low reset
//   start_i         request, sampled only in IDLE
//   action_i        0=down(+W) 1=right(+1) 2=up(-W) 3=left(-1), others no-op
//   cur_state_i     current state (1-based, row-major, 0 = invalid)
//   target_state_i  goal state
//   blocked_i       packed blocked list, entry i at [i*SW +: SW]
//   blocked_vld_i   per-entry enable
//   busy_o          high whenever not IDLE
//   timer_start_o   high in IDLE only
//   done_o          one-cycle pulse while in RESP
//   next_state_o    resolved next state, held until the next RESP
//   outcome_o       00=MOVED 01=EDGE 10=BLOCKED 11=GOAL
module q_move_resolver #(
  parameter int GRID_W = 6,
  parameter int GRID_H = 6,
  parameter int NBLK   = 16,
  parameter int SW     = 6,
  parameter int AW     = 2
) (
  input  logic               done_clk,
  input  logic               rst,
  input  logic               start_i,
  input  logic [AW-1:0]      action_i,
  input  logic [SW-1:0]      cur_state_i,
  input  logic [SW-1:0]      target_state_i,
  input  logic [NBLK*SW-1:0] blocked_i,
  input  logic [NBLK-1:0]    blocked_vld_i,
  output logic               busy_o,
  output logic               timer_start_o,
  output logic               done_o,
  output logic [SW-1:0]      next_state_o,
  output logic [1:0]         outcome_o
);

  localparam int IW = (NBLK > 1) ? $clog2(NBLK) : 1;

  // Candidate arithmetic is one bit wider than a state so +W never wraps.
  localparam logic [SW:0] L_W     = (SW+1)'(GRID_W);
  localparam logic [SW:0] L_NCELL = (SW+1)'(GRID_W * GRID_H);
  localparam logic [SW:0] L_ONE   = (SW+1)'(1);

  localparam logic [1:0] OC_MOVED   = 2'b00;
  localparam logic [1:0] OC_EDGE    = 2'b01;
  localparam logic [1:0] OC_BLOCKED = 2'b10;
  localparam logic [1:0] OC_GOAL    = 2'b11;

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_SCAN, S_RESP} state_t;

  state_t          r_state;
  logic            r_calc_ph;   // CALC: 0 = evaluate move, 1 = dispatch
  logic [AW-1:0]   r_act;
  logic [SW-1:0]   r_cur;
  logic [SW-1:0]   r_tgt;
  logic [SW:0]     r_cand;
  logic            r_edge;
  logic [IW-1:0]   r_idx;
  logic            r_busy;
  logic            r_timer_start;
  logic            r_done;
  logic [SW-1:0]   r_next;
  logic [1:0]      r_outcome;

  logic [SW:0]     w_cur_x;
  logic [SW:0]     w_col;
  logic [SW:0]     w_cand;
  logic            w_edge;
  logic            w_hit;
  logic            w_last;
  logic [SW-1:0]   w_blk [NBLK];

  // Unpack the flat blocked list into an indexable array.
  for (genvar gi = 0; gi < NBLK; gi++) begin : g_blk
    assign w_blk[gi] = blocked_i[gi*SW +: SW];
  end

  assign w_cur_x = {1'b0, r_cur};
  // Only meaningful for legal states; illegal states are flagged as EDGE first.
  assign w_col   = (w_cur_x - L_ONE) % L_W;

  always_comb begin
    w_cand = w_cur_x;
    w_edge = 1'b0;
    if ((w_cur_x == '0) || (w_cur_x > L_NCELL)) begin
      w_edge = 1'b1;
    end else if (r_act == AW'(0)) begin
      if (w_cur_x + L_W > L_NCELL) w_edge = 1'b1;
      else                         w_cand = w_cur_x + L_W;
    end else if (r_act == AW'(1)) begin
      if (w_col == L_W - L_ONE) w_edge = 1'b1;
      else                      w_cand = w_cur_x + L_ONE;
    end else if (r_act == AW'(2)) begin
      if (w_cur_x <= L_W) w_edge = 1'b1;
      else                w_cand = w_cur_x - L_W;
    end else if (r_act == AW'(3)) begin
      if (w_col == '0) w_edge = 1'b1;
      else             w_cand = w_cur_x - L_ONE;
    end else begin
      w_edge = 1'b1;
    end
  end

  assign w_hit  = blocked_vld_i[r_idx] && ({1'b0, w_blk[r_idx]} == r_cand);
  assign w_last = (r_idx == IW'(NBLK - 1));

  always_ff @(posedge done_clk) begin
    if (!rst) begin
      r_state       <= S_IDLE;
      r_calc_ph     <= 1'b0;
      r_act         <= '0;
      r_cur         <= '0;
      r_tgt         <= '0;
      r_cand        <= '0;
      r_edge        <= 1'b0;
      r_idx         <= '0;
      r_busy        <= 1'b0;
      r_timer_start <= 1'b1;
      r_done        <= 1'b0;
      r_next        <= SW'(1);
      r_outcome     <= OC_MOVED;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start_i) begin
            r_act         <= action_i;
            r_cur         <= cur_state_i;
            r_tgt         <= target_state_i;
            r_calc_ph     <= 1'b0;
            r_busy        <= 1'b1;
            r_timer_start <= 1'b0;
            r_state       <= S_CALC;
          end
        end
        S_CALC: begin
          if (!r_calc_ph) begin
            r_cand    <= w_cand;
            r_edge    <= w_edge;
            r_calc_ph <= 1'b1;
          end else if (r_edge) begin
            r_next    <= r_cur;
            r_outcome <= OC_EDGE;
            r_done    <= 1'b1;
            r_state   <= S_RESP;
          end else begin
            r_idx   <= '0;
            r_state <= S_SCAN;
          end
        end
        S_SCAN: begin
          if (w_hit) begin
            // Blocked takes priority over goal, so check it first.
            r_next    <= r_cur;
            r_outcome <= OC_BLOCKED;
            r_done    <= 1'b1;
            r_state   <= S_RESP;
          end else if (w_last) begin
            r_next    <= r_cand[SW-1:0];
            r_outcome <= (r_cand == {1'b0, r_tgt}) ? OC_GOAL : OC_MOVED;
            r_done    <= 1'b1;
            r_state   <= S_RESP;
          end else begin
            r_idx <= r_idx + IW'(1);
          end
        end
        S_RESP: begin
          r_done        <= 1'b0;
          r_busy        <= 1'b0;
          r_timer_start <= 1'b1;
          r_state       <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy_o        = r_busy;
  assign timer_start_o = r_timer_start;
  assign done_o        = r_done;
  assign next_state_o  = r_next;
  assign outcome_o     = r_outcome;

endmodule

// File: tb/tb_q_move_resolver.sv
// Testbench for q_move_resolver: a 6x6/16-entry instance and an 8x4/4-entry
// instance, checked against a row/column reference model.
module tb_q_move_resolver;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  // Main DUT (6x6, NBLK=16)
  logic        start;
  logic [1:0]  act;
  logic [5:0]  cur, tgt;
  logic [95:0] blocked;
  logic [15:0] blocked_vld;
  logic        busy, tmr, done;
  logic [5:0]  next_state;
  logic [1:0]  outcome;
  // Small DUT (8x4, NBLK=4)
  logic        s_start;
  logic [1:0]  s_act;
  logic [5:0]  s_cur, s_tgt;
  logic [23:0] s_blocked;
  logic [3:0]  s_blocked_vld;
  logic        s_busy, s_tmr, s_done;
  logic [5:0]  s_next_state;
  logic [1:0]  s_outcome;

  q_move_resolver #(.GRID_W(6), .GRID_H(6), .NBLK(16), .SW(6), .AW(2)) u_dut (
    .done_clk(clk), .rst(rst), .start_i(start), .action_i(act),
    .cur_state_i(cur), .target_state_i(tgt), .blocked_i(blocked),
    .blocked_vld_i(blocked_vld), .busy_o(busy), .timer_start_o(tmr),
    .done_o(done), .next_state_o(next_state), .outcome_o(outcome)
  );

  q_move_resolver #(.GRID_W(8), .GRID_H(4), .NBLK(4), .SW(6), .AW(2)) u_small (
    .done_clk(clk), .rst(rst), .start_i(s_start), .action_i(s_act),
    .cur_state_i(s_cur), .target_state_i(s_tgt), .blocked_i(s_blocked),
    .blocked_vld_i(s_blocked_vld), .busy_o(s_busy), .timer_start_o(s_tmr),
    .done_o(s_done), .next_state_o(s_next_state), .outcome_o(s_outcome)
  );

  int checks = 0;
  int errors = 0;

  int m_blk [16];
  bit m_vld [16];

  task automatic apply_blocks();
    for (int j = 0; j < 16; j++) begin
      blocked[j*6 +: 6] = m_blk[j][5:0];
      blocked_vld[j]    = m_vld[j];
    end
  endtask

  task automatic clear_blocks();
    for (int j = 0; j < 16; j++) begin
      m_blk[j] = 0;
      m_vld[j] = 1'b0;
    end
  endtask

  // Reference: row/column view of the maze, first enabled matching entry wins.
  // Latency in edges after the sampling edge until done_o is seen high.
  function automatic void model(input int w, input int h, input int nb, input bit use_blk,
                                input int c_state, input int a, input int t,
                                output int e_next, output int e_oc, output int e_lat);
    int row, col, cand;
    bit hit_edge;
    hit_edge = 1'b0;
    cand = c_state;
    if (c_state < 1 || c_state > w*h) hit_edge = 1'b1;
    else begin
      row = (c_state - 1) / w;
      col = (c_state - 1) % w;
      case (a)
        0: if (row == h-1) hit_edge = 1'b1; else cand = c_state + w;
        1: if (col == w-1) hit_edge = 1'b1; else cand = c_state + 1;
        2: if (row == 0)   hit_edge = 1'b1; else cand = c_state - w;
        3: if (col == 0)   hit_edge = 1'b1; else cand = c_state - 1;
        default: hit_edge = 1'b1;
      endcase
    end
    if (hit_edge) begin
      e_next = c_state; e_oc = 1; e_lat = 2;
      return;
    end
    if (use_blk) begin
      for (int j = 0; j < nb; j++) begin
        if (m_vld[j] && m_blk[j] == cand) begin
          e_next = c_state; e_oc = 2; e_lat = 3 + j;
          return;
        end
      end
    end
    e_next = cand;
    e_oc   = (cand == t) ? 3 : 0;
    e_lat  = 2 + nb;
  endfunction

  // Issues one request on the selected DUT and reports what came back.
  task automatic drive_req(input bit sel, input int c_state, input int a, input int t,
                           output int lat, output int nxt, output int oc,
                           output int width, output int busy1, output int tmr1);
    @(negedge clk);
    if (sel) begin
      s_cur = c_state[5:0]; s_act = a[1:0]; s_tgt = t[5:0]; s_start = 1'b1;
    end else begin
      cur = c_state[5:0]; act = a[1:0]; tgt = t[5:0]; start = 1'b1;
    end
    @(posedge clk); #1;
    start = 1'b0; s_start = 1'b0;
    busy1 = sel ? int'(s_busy) : int'(busy);
    tmr1  = sel ? int'(s_tmr)  : int'(tmr);
    lat = -1; nxt = -1; oc = -1; width = 0;
    for (int n = 1; n <= 60; n++) begin
      @(posedge clk); #1;
      if (sel ? s_done : done) begin
        lat = n;
        nxt = sel ? int'(s_next_state) : int'(next_state);
        oc  = sel ? int'(s_outcome) : int'(outcome);
        break;
      end
    end
    if (lat > 0) begin
      @(posedge clk); #1;
      width = (sel ? s_done : done) ? 2 : 1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks += 5;
    if (busy !== 1'b0)       begin errors++; $display("FAIL reset_busy got=%0b exp=0", busy); end
    if (tmr !== 1'b1)        begin errors++; $display("FAIL reset_timer got=%0b exp=1", tmr); end
    if (done !== 1'b0)       begin errors++; $display("FAIL reset_done got=%0b exp=0", done); end
    if (next_state !== 6'd1) begin errors++; $display("FAIL reset_next got=%0d exp=1", next_state); end
    if (outcome !== 2'b00)   begin errors++; $display("FAIL reset_outcome got=%0d exp=0", outcome); end
    $display("reset: busy=%0b timer=%0b done=%0b next=%0d outcome=%0d", busy, tmr, done, next_state, outcome);
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_directed();
    // cur, act, tgt, block setup (0 none, 1 entries 1/3 = 14, 2 entry 0 = 36)
    int tab [7][4] = '{'{8,1,36,0}, '{6,1,36,0}, '{3,2,36,0}, '{31,0,36,0},
                       '{8,0,36,1}, '{30,0,36,0}, '{30,0,36,2}};
    int lat, nxt, oc, width, b1, t1, e_next, e_oc, e_lat;
    for (int i = 0; i < 7; i++) begin
      clear_blocks();
      if (tab[i][3] == 1) begin
        m_blk[1] = 14; m_vld[1] = 1'b0;
        m_blk[3] = 14; m_vld[3] = 1'b1;
      end else if (tab[i][3] == 2) begin
        m_blk[0] = 36; m_vld[0] = 1'b1;
      end
      apply_blocks();
      model(6, 6, 16, 1'b1, tab[i][0], tab[i][1], tab[i][2], e_next, e_oc, e_lat);
      drive_req(1'b0, tab[i][0], tab[i][1], tab[i][2], lat, nxt, oc, width, b1, t1);
      checks += 6;
      if (lat !== e_lat)  begin errors++; $display("FAIL dir%0d_latency got=%0d exp=%0d", i, lat, e_lat); end
      if (nxt !== e_next) begin errors++; $display("FAIL dir%0d_next got=%0d exp=%0d", i, nxt, e_next); end
      if (oc !== e_oc)    begin errors++; $display("FAIL dir%0d_outcome got=%0d exp=%0d", i, oc, e_oc); end
      if (width !== 1)    begin errors++; $display("FAIL dir%0d_done_width got=%0d exp=1", i, width); end
      if (b1 !== 1)       begin errors++; $display("FAIL dir%0d_busy got=%0d exp=1", i, b1); end
      if (t1 !== 0)       begin errors++; $display("FAIL dir%0d_timer got=%0d exp=0", i, t1); end
      $display("directed %0d: cur=%0d act=%0d -> next=%0d oc=%0d lat=%0d", i, tab[i][0], tab[i][1], nxt, oc, lat);
    end
  endtask

  task automatic test_hold();
    int held;
    held = int'(next_state);
    @(negedge clk);
    cur = 6'd20; act = 2'd3;
    repeat (5) @(posedge clk);
    #1;
    checks += 2;
    if (int'(next_state) !== held) begin errors++; $display("FAIL hold_next got=%0d exp=%0d", next_state, held); end
    if (done !== 1'b0)             begin errors++; $display("FAIL hold_done got=%0b exp=0", done); end
    $display("hold: next=%0d", next_state);
  endtask

  task automatic test_random();
    int lat, nxt, oc, width, b1, t1, e_next, e_oc, e_lat, c_state, a, t;
    for (int i = 0; i < 40; i++) begin
      for (int j = 0; j < 16; j++) begin
        m_blk[j] = $urandom_range(1, 36);
        m_vld[j] = ($urandom_range(0, 3) == 0);
      end
      apply_blocks();
      c_state = $urandom_range(0, 38);
      a = $urandom_range(0, 3);
      t = $urandom_range(1, 36);
      if ($urandom_range(0, 2) == 0) begin
        model(6, 6, 16, 1'b0, c_state, a, 0, e_next, e_oc, e_lat);
        t = e_next;
      end
      model(6, 6, 16, 1'b1, c_state, a, t, e_next, e_oc, e_lat);
      drive_req(1'b0, c_state, a, t, lat, nxt, oc, width, b1, t1);
      checks += 4;
      if (lat !== e_lat)  begin errors++; $display("FAIL rnd%0d_latency got=%0d exp=%0d", i, lat, e_lat); end
      if (nxt !== e_next) begin errors++; $display("FAIL rnd%0d_next got=%0d exp=%0d", i, nxt, e_next); end
      if (oc !== e_oc)    begin errors++; $display("FAIL rnd%0d_outcome got=%0d exp=%0d", i, oc, e_oc); end
      if (width !== 1)    begin errors++; $display("FAIL rnd%0d_done_width got=%0d exp=1", i, width); end
      $display("random %0d: cur=%0d act=%0d tgt=%0d -> next=%0d oc=%0d lat=%0d", i, c_state, a, t, nxt, oc, lat);
    end
  endtask

  task automatic test_reset_mid();
    int pulses;
    clear_blocks();
    apply_blocks();
    @(negedge clk);
    cur = 6'd8; act = 2'd1; tgt = 6'd36; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (7) @(posedge clk);   // scan index is now 5
    #1;
    rst = 1'b0;
    @(posedge clk); #1;
    checks += 5;
    if (busy !== 1'b0)       begin errors++; $display("FAIL midrst_busy got=%0b exp=0", busy); end
    if (tmr !== 1'b1)        begin errors++; $display("FAIL midrst_timer got=%0b exp=1", tmr); end
    if (done !== 1'b0)       begin errors++; $display("FAIL midrst_done got=%0b exp=0", done); end
    if (next_state !== 6'd1) begin errors++; $display("FAIL midrst_next got=%0d exp=1", next_state); end
    if (outcome !== 2'b00)   begin errors++; $display("FAIL midrst_outcome got=%0d exp=0", outcome); end
    rst = 1'b1;
    pulses = 0;
    for (int n = 0; n < 30; n++) begin
      @(posedge clk); #1;
      if (done) pulses++;
    end
    checks++;
    if (pulses !== 0) begin errors++; $display("FAIL midrst_no_done got=%0d exp=0", pulses); end
    $display("mid-scan reset: busy=%0b timer=%0b done pulses after=%0d", busy, tmr, pulses);
  endtask

  task automatic test_busy_start();
    int pulses;
    clear_blocks();
    apply_blocks();
    @(negedge clk);
    cur = 6'd8; act = 2'd1; tgt = 6'd36; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    pulses = 0;
    for (int n = 1; n <= 50; n++) begin
      if (n >= 3 && n <= 10) start = 1'b1;
      else start = 1'b0;
      @(posedge clk); #1;
      if (done) pulses++;
    end
    start = 1'b0;
    checks += 2;
    if (pulses !== 1)      begin errors++; $display("FAIL busy_start_pulses got=%0d exp=1", pulses); end
    if (next_state !== 9)  begin errors++; $display("FAIL busy_start_next got=%0d exp=9", next_state); end
    $display("start while busy: done pulses=%0d next=%0d", pulses, next_state);
  endtask

  task automatic test_small_grid();
    int tab [4][3] = '{'{16,1,30}, '{9,3,30}, '{26,0,30}, '{10,1,30}};
    int lat, nxt, oc, width, b1, t1, e_next, e_oc, e_lat;
    for (int i = 0; i < 4; i++) begin
      model(8, 4, 4, 1'b0, tab[i][0], tab[i][1], tab[i][2], e_next, e_oc, e_lat);
      drive_req(1'b1, tab[i][0], tab[i][1], tab[i][2], lat, nxt, oc, width, b1, t1);
      checks += 4;
      if (lat !== e_lat)  begin errors++; $display("FAIL small%0d_latency got=%0d exp=%0d", i, lat, e_lat); end
      if (nxt !== e_next) begin errors++; $display("FAIL small%0d_next got=%0d exp=%0d", i, nxt, e_next); end
      if (oc !== e_oc)    begin errors++; $display("FAIL small%0d_outcome got=%0d exp=%0d", i, oc, e_oc); end
      if (width !== 1)    begin errors++; $display("FAIL small%0d_done_width got=%0d exp=1", i, width); end
      $display("small grid %0d: cur=%0d act=%0d -> next=%0d oc=%0d lat=%0d", i, tab[i][0], tab[i][1], nxt, oc, lat);
    end
  endtask

  initial begin
    rst = 1'b0;
    start = 1'b0; act = '0; cur = '0; tgt = '0; blocked = '0; blocked_vld = '0;
    s_start = 1'b0; s_act = '0; s_cur = '0; s_tgt = '0; s_blocked = '0; s_blocked_vld = '0;
    test_reset();
    test_directed();
    test_hold();
    test_random();
    test_reset_mid();
    test_busy_start();
    test_small_grid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
